// File: rtl/shift_sipo_slave.sv
// Serial-in parallel-out bus slave.
// Receives an address byte MSB first. If the address matches, it acknowledges and then
// receives data bytes, acknowledging each one, until Stop or a repeated Start.
module shift_sipo_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic       Stop,
    input  logic       En,
    input  logic       Sin,
    output logic [7:0] Data,
    output logic       DataValid,
    output logic       Ack,
    output logic       AddrMatch,
    output logic       RW,
    output logic       Busy
);

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StAckA,
        StData,
        StAckD
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  sr_q, sr_d;
    logic [7:0]  data_q, data_d;
    logic        dv_q, dv_d;
    logic        ack_q, ack_d;
    logic        am_q, am_d;
    logic        rw_q, rw_d;
    logic [7:0]  byte_w;

    // Byte as it would look with the current serial bit shifted in
    assign byte_w = {sr_q[6:0], Sin};

    // Next-state and registered-output logic; Stop beats Start beats En
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        am_d    = am_q;
        rw_d    = rw_q;

        if (Stop && (state_q != StIdle)) begin
            // Abort the frame and drop any partial byte. Data is kept.
            state_d = StIdle;
            cnt_d   = 4'd0;
            sr_d    = 8'h00;
            am_d    = 1'b0;
            rw_d    = 1'b0;
        end else if (Start) begin
            // Start or repeated start. Any Ack or DataValid due on this edge is suppressed.
            state_d = StAddr;
            cnt_d   = 4'd0;
            sr_d    = 8'h00;
            am_d    = 1'b0;
            rw_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                end
                StAddr: begin
                    if (En) begin
                        sr_d  = byte_w;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d = 4'd0;
                            if (byte_w[7:1] == SLAVE_ADDR) begin
                                state_d = StAckA;
                                am_d    = 1'b1;
                                rw_d    = byte_w[0];
                            end else begin
                                state_d = StIdle;
                            end
                        end
                    end
                end
                StAckA: begin
                    state_d = StData;
                    cnt_d   = 4'd0;
                end
                StData: begin
                    if (En) begin
                        sr_d  = byte_w;
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            cnt_d   = 4'd0;
                            data_d  = byte_w;
                            dv_d    = 1'b1;
                            state_d = StAckD;
                        end
                    end
                end
                StAckD: begin
                    state_d = StData;
                    cnt_d   = 4'd0;
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                    sr_d    = 8'h00;
                end
            endcase
        end

        // Ack is high during exactly the cycle spent in an acknowledge state
        ack_d = (state_d == StAckA) || (state_d == StAckD);
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            sr_q    <= 8'h00;
            data_q  <= 8'h00;
            dv_q    <= 1'b0;
            ack_q   <= 1'b0;
            am_q    <= 1'b0;
            rw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            ack_q   <= ack_d;
            am_q    <= am_d;
            rw_q    <= rw_d;
        end
    end

    assign Data      = data_q;
    assign DataValid = dv_q;
    assign Ack       = ack_q;
    assign AddrMatch = am_q;
    assign RW        = rw_q;
    assign Busy      = (state_q != StIdle);

endmodule

// File: tb/tb_shift_sipo_slave.sv
// Directed bench for shift_sipo_slave with hand-computed expectations.
module tb_shift_sipo_slave;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       en;
    logic       sin;
    logic [7:0] data;
    logic       data_valid;
    logic       ack;
    logic       addr_match;
    logic       rw;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int dv_cnt = 0;
    int ack_cnt = 0;

    shift_sipo_slave #(
        .SLAVE_ADDR(7'h50)
    ) u_dut (
        .Clk      (clk),
        .Rst      (rst),
        .Start    (start),
        .Stop     (stop),
        .En       (en),
        .Sin      (sin),
        .Data     (data),
        .DataValid(data_valid),
        .Ack      (ack),
        .AddrMatch(addr_match),
        .RW       (rw),
        .Busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        dv_cnt  += int'(data_valid);
        ack_cnt += int'(ack);
    endtask

    task automatic send_bit(input logic b);
        en  = 1'b1;
        sin = b;
        tick();
        en  = 1'b0;
        sin = 1'b0;
    endtask

    // MSB first. With gaps set, bit i is followed by (i % 4) idle cycles.
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (gaps && i != 0) repeat (i % 4) tick();
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    initial begin
        logic [7:0] part;
        rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0; sin = 1'b0;
        repeat (2) tick();
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_data", int'(data), 8'h00);
        check_eq("rst_dv", int'(data_valid), 0);
        check_eq("rst_ack", int'(ack), 0);
        check_eq("rst_am", int'(addr_match), 0);
        check_eq("rst_rw", int'(rw), 0);
        rst = 1'b0;
        send_bit(1'b1);
        check_eq("nostart_busy", int'(busy), 0);

        // Matching write address 0xA0, then data 0x3C
        pulse_start();
        check_eq("t1_busy", int'(busy), 1);
        ack_cnt = 0;
        send_byte(8'hA0, 1'b0);
        check_eq("t1_ack_a", int'(ack), 1);
        check_eq("t1_ack_a_cnt", ack_cnt, 1);
        check_eq("t1_am", int'(addr_match), 1);
        check_eq("t1_rw", int'(rw), 0);
        tick();
        check_eq("t1_ack_a_end", int'(ack), 0);
        dv_cnt = 0;
        send_byte(8'h3C, 1'b0);
        check_eq("t1_data", int'(data), 8'h3C);
        check_eq("t1_dv", int'(data_valid), 1);
        check_eq("t1_dv_cnt", dv_cnt, 1);
        check_eq("t1_ack_d", int'(ack), 1);
        tick();
        check_eq("t1_dv_end", int'(data_valid), 0);
        check_eq("t1_ack_d_end", int'(ack), 0);
        check_eq("t1_am_hold", int'(addr_match), 1);

        // 0x5A with idle gaps between bits
        dv_cnt = 0;
        send_byte(8'h5A, 1'b1);
        check_eq("gap_data", int'(data), 8'h5A);
        check_eq("gap_dv_cnt", dv_cnt, 1);
        tick();
        check_eq("gap_dv_end", int'(data_valid), 0);

        // Stop after five data bits
        dv_cnt = 0;
        part = 8'hB0;
        for (int i = 7; i >= 3; i--) send_bit(part[i]);
        pulse_stop();
        check_eq("stop_busy", int'(busy), 0);
        check_eq("stop_am", int'(addr_match), 0);
        check_eq("stop_rw", int'(rw), 0);
        check_eq("stop_data", int'(data), 8'h5A);
        check_eq("stop_dv_cnt", dv_cnt, 0);

        // Non-matching address 0xA2
        pulse_start();
        ack_cnt = 0;
        dv_cnt = 0;
        send_byte(8'hA2, 1'b0);
        check_eq("mis_busy", int'(busy), 0);
        check_eq("mis_am", int'(addr_match), 0);
        send_byte(8'hFF, 1'b0);
        check_eq("mis_busy2", int'(busy), 0);
        check_eq("mis_ack_cnt", ack_cnt, 0);
        check_eq("mis_dv_cnt", dv_cnt, 0);
        check_eq("mis_data", int'(data), 8'h5A);

        // Repeated start during DATA, then read address 0xA1
        pulse_start();
        send_byte(8'hA0, 1'b0);
        tick();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        pulse_start();
        check_eq("rs_busy", int'(busy), 1);
        check_eq("rs_am", int'(addr_match), 0);
        check_eq("rs_ack", int'(ack), 0);
        ack_cnt = 0;
        send_byte(8'hA1, 1'b0);
        check_eq("rs_am2", int'(addr_match), 1);
        check_eq("rs_rw", int'(rw), 1);
        check_eq("rs_ack2", int'(ack), 1);
        check_eq("rs_ack_cnt", ack_cnt, 1);
        check_eq("rs_data", int'(data), 8'h5A);
        tick();
        pulse_stop();
        check_eq("rs_stop_rw", int'(rw), 0);

        // Reset mid-byte, just before the eighth data bit
        pulse_start();
        send_byte(8'hA0, 1'b0);
        tick();
        part = 8'h81;
        for (int i = 7; i >= 1; i--) send_bit(part[i]);
        en  = 1'b1;
        sin = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_eq("mrst_busy", int'(busy), 0);
        check_eq("mrst_data", int'(data), 8'h00);
        check_eq("mrst_am", int'(addr_match), 0);
        check_eq("mrst_ack", int'(ack), 0);
        dv_cnt = 0;
        ack_cnt = 0;
        tick();
        tick();
        en  = 1'b0;
        sin = 1'b0;
        rst = 1'b0;
        send_byte(8'hA0, 1'b0);
        check_eq("mrst_nostart_busy", int'(busy), 0);
        check_eq("mrst_dv_cnt", dv_cnt, 0);
        check_eq("mrst_ack_cnt", ack_cnt, 0);
        check_eq("mrst_am2", int'(addr_match), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
